// File: rtl/swipt_link_tx.sv
// SWIPT link carrier generator: programmable square wave with phase-continuous
// retuning through a sequential divider and a settle-time lock indicator.
module swipt_link_tx #(
  parameter int unsigned CLK_HZ         = 100000000,
  parameter int unsigned F_DEFAULT      = 40000,
  parameter int unsigned F_MIN          = 20000,
  parameter int unsigned F_MAX          = 80000,
  parameter int unsigned SETTLE_PERIODS = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swiptAlive,
  input  logic [31:0] f_req,
  input  logic        f_req_valid,
  output logic        f_req_ready,
  output logic [31:0] f_cur,
  output logic        link,
  output logic        period_strobe,
  output logic        freq_rdy
);

  localparam logic [31:0] CLK_W    = 32'(CLK_HZ);
  localparam logic [31:0] F_DEF_W  = 32'(F_DEFAULT);
  localparam logic [31:0] F_MIN_W  = 32'(F_MIN);
  localparam logic [31:0] F_MAX_W  = 32'(F_MAX);
  localparam logic [31:0] HALF_DEF = 32'(CLK_HZ / (2 * F_DEFAULT));
  localparam int          SW       = $clog2(SETTLE_PERIODS + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_PERIODS);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_PEND} state_t;

  state_t        state_q, state_d;
  logic [31:0]   half_q, half_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          link_q, link_d;
  logic          strobe_q, strobe_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [31:0]   f_cur_q, f_cur_d;
  logic [31:0]   fc_q, fc_d;
  logic [32:0]   rem_q, rem_d;
  logic [31:0]   quo_q, quo_d;
  logic [4:0]    div_cnt_q, div_cnt_d;

  logic [31:0] fc_in;
  logic [33:0] rem_sh;
  logic [32:0] divisor;
  logic        rise;
  logic        apply;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      half_q    <= HALF_DEF;
      cnt_q     <= HALF_DEF - 32'd1;
      link_q    <= 1'b0;
      strobe_q  <= 1'b0;
      settle_q  <= '0;
      f_cur_q   <= F_DEF_W;
      fc_q      <= F_DEF_W;
      rem_q     <= '0;
      quo_q     <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      cnt_q     <= cnt_d;
      link_q    <= link_d;
      strobe_q  <= strobe_d;
      settle_q  <= settle_d;
      f_cur_q   <= f_cur_d;
      fc_q      <= fc_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    cnt_d     = cnt_q;
    link_d    = link_q;
    strobe_d  = 1'b0;
    settle_d  = settle_q;
    f_cur_d   = f_cur_q;
    fc_d      = fc_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_cnt_d = div_cnt_q;

    if (f_req < F_MIN_W)      fc_in = F_MIN_W;
    else if (f_req > F_MAX_W) fc_in = F_MAX_W;
    else                      fc_in = f_req;

    divisor = {fc_q, 1'b0};
    rem_sh  = {rem_q, quo_q[31]};
    rise    = swiptAlive && (cnt_q == 32'd0) && !link_q;
    // Retune only on a rising edge so the carrier never glitches; when the
    // carrier is off there is no phase to preserve, so apply immediately.
    apply   = (state_q == S_PEND) && (swiptAlive ? rise : 1'b1);

    case (state_q)
      S_IDLE: begin
        if (f_req_valid && (fc_in != f_cur_q)) begin
          fc_d      = fc_in;
          rem_d     = '0;
          quo_d     = CLK_W;
          div_cnt_d = '0;
          state_d   = S_DIV;
        end
      end
      S_DIV: begin
        // One restoring step per cycle; dividend bits shift out of quo as
        // quotient bits shift in.
        if (rem_sh >= {1'b0, divisor}) begin
          rem_d = rem_sh[32:0] - divisor;
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_sh[32:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        div_cnt_d = div_cnt_q + 5'd1;
        if (div_cnt_q == 5'd31) begin
          if (quo_d == 32'd0) quo_d = 32'd1;
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (apply) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (apply) begin
      half_d  = quo_q;
      f_cur_d = fc_q;
    end

    if (!swiptAlive) begin
      link_d   = 1'b0;
      cnt_d    = half_d - 32'd1;
      settle_d = '0;
    end else if (cnt_q == 32'd0) begin
      link_d   = !link_q;
      cnt_d    = half_d - 32'd1;
      strobe_d = !link_q;
      if (rise) begin
        if (apply)                         settle_d = '0;
        else if (settle_q != SETTLE_MAX)   settle_d = settle_q + SW'(1);
      end
    end else begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  assign f_req_ready   = (state_q == S_IDLE);
  assign f_cur         = f_cur_q;
  assign link          = link_q;
  assign period_strobe = strobe_q;
  assign freq_rdy      = (settle_q == SETTLE_MAX);

endmodule

// File: tb/tb_swipt_link_tx.sv
// Directed bench for swipt_link_tx: carrier timing, retuning, clamping,
// enable gating and reset during a division.
module tb_swipt_link_tx;

  // 10 MHz clock: half periods 125 (40 kHz), 100 (50 kHz), 62 (80 kHz), 250 (20 kHz)
  logic        clk = 1'b0;
  logic        nrst;
  logic        swipt_alive;
  logic [31:0] f_req;
  logic        f_req_valid;
  logic        f_req_ready;
  logic [31:0] f_cur;
  logic        link;
  logic        period_strobe;
  logic        freq_rdy;

  swipt_link_tx #(
    .CLK_HZ(10000000), .F_DEFAULT(40000), .F_MIN(20000), .F_MAX(80000), .SETTLE_PERIODS(16)
  ) dut (
    .clk(clk), .nrst(nrst), .swiptAlive(swipt_alive),
    .f_req(f_req), .f_req_valid(f_req_valid), .f_req_ready(f_req_ready),
    .f_cur(f_cur), .link(link), .period_strobe(period_strobe), .freq_rdy(freq_rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int last_rise = 0;
  int cur_period = 250;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic wait_rise(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (period_strobe) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("rise_timeout", 32'd0, 32'd1);
    else last_rise = at;
  endtask

  task automatic send_req(input logic [31:0] f, output int acc);
    f_req       = f;
    f_req_valid = 1'b1;
    @(negedge clk);
    acc         = cyc;
    f_req_valid = 1'b0;
    f_req       = 32'hDEAD_BEEF;
    $display("req f=%0d accepted_edge=%0d f_cur=%0d", f, acc, f_cur);
  endtask

  // Freq_rdy must stay low through strobe 15 and rise exactly on strobe 16.
  task automatic settle(input int k0);
    int at;
    for (int k = k0; k <= 16; k++) begin
      wait_rise(2 * cur_period + 50, at);
      if (k == 15) check("rdy_early", 32'(freq_rdy), 32'd0);
      if (k == 16) check("rdy_on_16", 32'(freq_rdy), 32'd1);
    end
  endtask

  task automatic freq_change(input logic [31:0] f, input logic [31:0] exp_f,
                             input int exp_period, input bit poke);
    int acc, exp_at, at, at2;
    send_req(f, acc);
    for (int i = 0; i < 32; i++) begin
      if (poke && i == 4) begin
        f_req = 32'd20000;
        f_req_valid = 1'b1;
      end else begin
        f_req_valid = 1'b0;
      end
      @(negedge clk);
    end
    f_req_valid = 1'b0;
    check("ready_low_div", 32'(f_req_ready), 32'd0);
    exp_at = last_rise;
    while (exp_at <= acc + 32) exp_at += cur_period;
    wait_rise(2 * cur_period + 50, at);
    check("apply_edge", 32'(at), 32'(exp_at));
    check("apply_fcur", f_cur, exp_f);
    check("apply_ready", 32'(f_req_ready), 32'd1);
    check("apply_rdy_drop", 32'(freq_rdy), 32'd0);
    wait_rise(2 * exp_period + 50, at2);
    check("new_period", 32'(at2 - at), 32'(exp_period));
    cur_period = exp_period;
    $display("applied f_cur=%0d at edge %0d period=%0d", f_cur, at, at2 - at);
  endtask

  initial begin
    int c0, at, at2, acc, prev;
    nrst = 1'b0; swipt_alive = 1'b1; f_req_valid = 1'b0; f_req = '0;
    repeat (3) @(negedge clk);
    check("rst_link", 32'(link), 32'd0);
    check("rst_strobe", 32'(period_strobe), 32'd0);
    check("rst_rdy", 32'(freq_rdy), 32'd0);
    check("rst_ready", 32'(f_req_ready), 32'd1);
    check("rst_fcur", f_cur, 32'd40000);

    nrst = 1'b1; c0 = cyc;
    wait_rise(400, at);
    check("first_rise", 32'(at - c0), 32'd125);
    check("strobe_link", 32'(link), 32'd1);
    wait_rise(600, at2);
    check("period_40k", 32'(at2 - at), 32'd250);
    settle(3);

    freq_change(32'd50000, 32'd50000, 200, 1'b0);
    settle(2);

    // Same frequency again: dropped, nothing disturbed.
    prev = last_rise;
    send_req(32'd50000, acc);
    check("dup_ready", 32'(f_req_ready), 32'd1);
    check("dup_rdy", 32'(freq_rdy), 32'd1);
    wait_rise(500, at);
    check("dup_period", 32'(at - prev), 32'd200);

    // Carrier enable dropped while link is high.
    repeat (50) @(negedge clk);
    swipt_alive = 1'b0;
    @(negedge clk);
    check("off_link", 32'(link), 32'd0);
    check("off_rdy", 32'(freq_rdy), 32'd0);
    repeat (20) @(negedge clk);
    swipt_alive = 1'b1; c0 = cyc;
    wait_rise(400, at);
    check("reenable_rise", 32'(at - c0), 32'd100);
    settle(2);

    // Clamp high, with a request poked during DIV that must be ignored.
    freq_change(32'd100000, 32'd80000, 124, 1'b1);
    repeat (200) @(negedge clk);
    check("ignored_fcur", f_cur, 32'd80000);
    check("ignored_ready", 32'(f_req_ready), 32'd1);
    wait_rise(400, at);
    freq_change(32'd10000, 32'd20000, 500, 1'b0);

    // Reset in the middle of a division discards the request.
    send_req(32'd60000, acc);
    repeat (10) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("midrst_fcur", f_cur, 32'd40000);
    check("midrst_ready", 32'(f_req_ready), 32'd1);
    check("midrst_link", 32'(link), 32'd0);
    @(negedge clk);
    nrst = 1'b1; c0 = cyc;
    wait_rise(400, at);
    check("midrst_rise", 32'(at - c0), 32'd125);
    wait_rise(600, at2);
    check("midrst_period", 32'(at2 - at), 32'd250);
    check("midrst_fcur_after", f_cur, 32'd40000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/swipt_link_tx.md
Name: swipt_link_tx

Overview:
Transmit-side carrier generator for the SWIPT link. It produces the square-wave `link` signal that the receiver-side PLL locks onto, at a programmable frequency. Frequency requests arrive over a valid/ready handshake. A sequential divider converts each request into a half-period count, and the new count is applied phase-continuously at the next carrier period boundary. `freq_rdy` tells downstream logic when the carrier has been stable long enough for the far end to lock.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
F_DEFAULT, 40000, carrier frequency in Hz after reset
F_MIN, 20000, lower clamp for requested frequency in Hz
F_MAX, 80000, upper clamp for requested frequency in Hz
SETTLE_PERIODS, 16, full carrier periods at a new frequency before freq_rdy asserts

Ports:
clk  input  1  system clock, all logic on rising edge
nrst  input  1  asynchronous active-low reset
swiptAlive  input  1  carrier enable; low forces link low
f_req  input  32  requested carrier frequency in Hz
f_req_valid  input  1  f_req is valid this cycle
f_req_ready  output  1  block can accept a request
f_cur  output  32  frequency currently driven on link, in Hz (clamped value)
link  output  1  carrier square wave, 50% duty
period_strobe  output  1  one-cycle pulse on each link 0->1 transition
freq_rdy  output  1  carrier stable for SETTLE_PERIODS periods

Behaviour:
- Reset (nrst low, asynchronous):
  - link=0, period_strobe=0, freq_rdy=0, f_req_ready=1, f_cur=F_DEFAULT.
  - half=CLK_HZ/(2*F_DEFAULT), an elaboration-time constant (1250 at defaults).
  - cnt=half-1, settle count=0, pending=0, FSM=IDLE.
- Carrier generation:
  - While swiptAlive=1, cnt decrements each cycle.
  - At cnt==0: link toggles and cnt reloads half-1. Period is exactly 2*half cycles.
  - On a 0->1 toggle, period_strobe is high for that one cycle.
- swiptAlive low:
  - Synchronously forces link=0, cnt=half-1, settle count=0, freq_rdy=0.
  - After swiptAlive rises, the first link rising edge occurs exactly half cycles later.
- Request FSM, states IDLE, DIV, PEND:
  - IDLE: f_req_ready=1. When f_req_valid&&f_req_ready, the request is accepted:
    - fc=clamp(f_req, F_MIN, F_MAX) is latched; go to DIV.
    - If fc==f_cur, the request is accepted and dropped (stay IDLE, no effect on freq_rdy).
  - DIV: f_req_ready=0. A restoring 32-bit unsigned divider computes q=floor(CLK_HZ/(2*fc)) in exactly 32 cycles. If q==0, force q=1. Go to PEND.
  - PEND: f_req_ready=0.
    - swiptAlive=1: at the next link 0->1 toggle, half<=q, f_cur<=fc, the reload uses q-1, settle count=0, freq_rdy<=0; go to IDLE.
    - swiptAlive=0: apply on the next cycle and go to IDLE.
- Request latency: acceptance to f_req_ready high again is 32 cycles plus the wait to the next period boundary (at most 2*old half).
- freq_rdy: the settle count increments on each period_strobe, saturating at SETTLE_PERIODS. freq_rdy=1 while count==SETTLE_PERIODS.
- Simultaneous events:
  - Apply and a toggle on the same cycle: the toggle uses the new half.
  - Requests while not ready are ignored; f_req is not sampled.
- Arithmetic: all values are unsigned 32-bit. 2*fc is computed in 33 bits; no overflow is possible for legal parameters.
- Reset mid-DIV or mid-PEND discards the request; state returns to reset values.

Test Plan:
- Reset, swiptAlive=1 → first link rise 1250 cycles later, period 2500 cycles. freq_rdy rises on the 16th period_strobe.
- Request 50000 while running → f_req_ready low for 32 cycles plus the wait to the boundary. From the next rising edge, period is 2000 cycles and f_cur=50000. freq_rdy drops at that edge and reasserts 16 strobes later.
- Request 100000 → clamped: f_cur=80000, period 1250 cycles. Request 10000 → f_cur=20000, period 5000 cycles.
- Request 40000 while f_cur=40000 → f_req_ready high the next cycle, freq_rdy and link timing unchanged.
- Drop swiptAlive mid-period → link=0 and freq_rdy=0 the next cycle. Re-enable → rise after half cycles, freq_rdy after 16 strobes.
- Assert nrst low during DIV of a 60000 request → f_cur=40000, f_req_ready=1, and no frequency change afterwards.
